// File: rtl/sprite_rom_mux.sv
// Sprite ROM channel mux: shared ROM address, latency-matched index pipe,
// per-pixel slice select. SPRITE_KEY_EN enables KEY_COLOR transparency.
module sprite_rom_mux #(
  parameter int NUM_OBJ = 8,
  parameter int COLOR_W = 12,
  parameter int ROM_LAT = 1,
  parameter int IDX_W   = 4,
  parameter logic [COLOR_W-1:0] BG_COLOR  = 12'h000,
  parameter logic [COLOR_W-1:0] KEY_COLOR = 12'hF0F
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  input  logic [9:0]                 row,
  input  logic [9:0]                 col,
  input  logic [IDX_W-1:0]           index,
  output logic [9:0]                 rom_row,
  output logic [9:0]                 rom_col,
  input  logic [NUM_OBJ*COLOR_W-1:0] rom_data,
  output logic [COLOR_W-1:0]         color_data,
  output logic                       out_valid,
  output logic                       hit
);

  localparam int DEPTH = 1 + ROM_LAT;

  logic [DEPTH-1:0] vld_q;
  logic [IDX_W-1:0] idx_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      rom_row <= '0;
      rom_col <= '0;
    end else begin
      rom_row <= row;
      rom_col <= col;
    end
  end

  // Valid/index ride alongside the ROM so they line up with rom_data.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      for (int s = 0; s < DEPTH; s++)
        idx_q[s] <= '0;
    end else begin
      vld_q    <= {vld_q[DEPTH-2:0], req_valid};
      idx_q[0] <= index;
      for (int s = 1; s < DEPTH; s++)
        idx_q[s] <= idx_q[s-1];
    end
  end

  logic                 vld_a;
  logic [IDX_W-1:0]     idx_a;
  logic [COLOR_W-1:0]   slice_sel;
  logic                 in_range;
  logic                 opaque;

  assign vld_a = vld_q[DEPTH-1];
  assign idx_a = idx_q[DEPTH-1];

  always_comb begin
    slice_sel = BG_COLOR;
    in_range  = 1'b0;
    for (int k = 1; k <= NUM_OBJ; k++) begin
      if (idx_a == IDX_W'(k)) begin
        slice_sel = rom_data[(k-1)*COLOR_W +: COLOR_W];
        in_range  = 1'b1;
      end
    end
  end

`ifdef SPRITE_KEY_EN
  assign opaque = in_range && (slice_sel != KEY_COLOR);
`else
  assign opaque = in_range;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      color_data <= BG_COLOR;
      out_valid  <= 1'b0;
      hit        <= 1'b0;
    end else begin
      out_valid  <= vld_a;
      hit        <= vld_a && opaque;
      color_data <= (vld_a && opaque) ? slice_sel : BG_COLOR;
    end
  end

endmodule

// File: doc/sprite_rom_mux.md
SPRITE_ROM_MUX -- requirements
Module: sprite_rom_mux

Interface
REQ-001 Parameter NUM_OBJ, default 8: number of object ROM channels; legal range 1..15.
REQ-002 Parameter COLOR_W, default 12: pixel color width in bits (4:4:4 RGB).
REQ-003 Parameter ROM_LAT, default 1: external ROM read latency in cycles; legal range 1..4.
REQ-004 Parameter IDX_W, default 4: object index width; SHALL satisfy 2^IDX_W > NUM_OBJ.
REQ-005 Parameter BG_COLOR, default 12'h000: color driven for no-object or invalid pixels.
REQ-006 Parameter KEY_COLOR, default 12'hF0F: transparency key color; used only under SPRITE_KEY_EN.
REQ-007 clk  input  1  single system clock; all state changes on its rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 req_valid  input  1  pixel request strobe; one request per cycle max.
REQ-010 row  input  10  pixel row within the object bitmap.
REQ-011 col  input  10  pixel column within the object bitmap.
REQ-012 index  input  IDX_W  object select; 0 = none, k = object k (1..NUM_OBJ).
REQ-013 rom_row  output  10  registered row address shared by all object ROMs.
REQ-014 rom_col  output  10  registered column address shared by all object ROMs.
REQ-015 rom_data  input  NUM_OBJ*COLOR_W  concatenated ROM outputs; object k occupies bits [k*COLOR_W-1 : (k-1)*COLOR_W].
REQ-016 color_data  output  COLOR_W  registered selected pixel color.
REQ-017 out_valid  output  1  color_data corresponds to a request.
REQ-018 hit  output  1  color_data is an opaque object pixel.

Function
REQ-019 The block SHALL capture row/col into rom_row/rom_col every cycle regardless of req_valid.
REQ-020 The block SHALL carry req_valid and index through a delay pipeline of exactly 1+ROM_LAT stages aligned with rom_data.
REQ-021 Total latency SHALL be 2+ROM_LAT cycles: a request at cycle N produces out_valid=1 at cycle N+2+ROM_LAT.
REQ-022 Throughput SHALL be one result per cycle for back-to-back requests, with no bubbles and results in request order.
REQ-023 For an aligned index k in 1..NUM_OBJ, color_data SHALL equal the k-th rom_data slice and hit SHALL be 1.
REQ-024 For an aligned index of 0 or greater than NUM_OBJ, the block SHALL drive color_data=BG_COLOR and hit=0, with out_valid still 1.
REQ-025 When out_valid=0, the block SHALL drive color_data=BG_COLOR and hit=0.
REQ-026 Index changes between requests SHALL take effect per pixel, with no cross-contamination between adjacent results.

Reset
REQ-027 While reset=1, rom_row, rom_col and all pipeline index stages SHALL be 0, all valid stages SHALL be 0, color_data SHALL be BG_COLOR, and out_valid and hit SHALL be 0.
REQ-028 Reset asserted mid-stream SHALL discard all in-flight requests; no out_valid pulse SHALL appear for requests issued at or before the reset cycle.
REQ-029 A request issued in the first cycle after reset deasserts SHALL complete normally with latency 2+ROM_LAT.

Configuration
REQ-030 Macro SPRITE_KEY_EN defined: when the selected slice equals KEY_COLOR, the block SHALL drive color_data=BG_COLOR and hit=0.
REQ-031 Macro SPRITE_KEY_EN undefined: KEY_COLOR SHALL be ignored, and any in-range index SHALL give hit=1 with the raw slice color.

Verification
REQ-032 The bench SHALL check latency: with ROM_LAT=1 and req_valid pulsed at cycle 10 with index=2 and slice 2 = 12'hABC, it SHALL observe out_valid=1, color_data=12'hABC and hit=1 at cycle 13 only.
REQ-033 The bench SHALL check streaming: 8 back-to-back requests with index=1..8 SHALL yield 8 consecutive results, each the matching slice.
REQ-034 The bench SHALL check out-of-range selection: index=0 and index=9 (NUM_OBJ=8) SHALL each give color_data=12'h000, hit=0 and out_valid=1.
REQ-035 The bench SHALL check transparency: with SPRITE_KEY_EN defined and slice 3 = 12'hF0F, index=3 SHALL give 12'h000 with hit=0; with the macro undefined it SHALL give 12'hF0F with hit=1.
REQ-036 The bench SHALL check reset flush: with ROM_LAT=3, reset asserted for 1 cycle while 4 requests are in flight SHALL produce no out_valid pulses, and a request issued after reset SHALL complete 5 cycles later.
